// File: rtl/boton_pkg.sv
// Shared types and default timing constants
// for the push-button conditioner.
package boton_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRESS = 2'd1,
      LONG  = 2'd2,
      FIRE  = 2'd3
   } state_t;

   localparam int MIN_TIME_DEF        = 500;
   localparam int TIME_ANTIREBOTE_DEF = 10;

endpackage

// File: rtl/boton_antirebote.sv
// Two-flop synchroniser plus debounce filter:
// the level follows the input only after it has been stable for the window.
module boton_antirebote
   import boton_pkg::*;
#(
   parameter int TIME_ANTIREBOTE = TIME_ANTIREBOTE_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic btn_deb
);

   localparam int DW = $clog2(TIME_ANTIREBOTE + 1);
   localparam logic [DW-1:0] DLAST = DW'(TIME_ANTIREBOTE - 1);

   logic          s1;
   logic          sync;
   logic [DW-1:0] dcnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1      <= 1'b0;
         sync    <= 1'b0;
         btn_deb <= 1'b0;
         dcnt    <= '0;
      end else begin
         s1   <= btn_in;
         sync <= s1;
         // any return to the current level restarts the window
         if (sync == btn_deb) begin
            dcnt <= '0;
         end else if (dcnt == DLAST) begin
            btn_deb <= sync;
            dcnt    <= '0;
         end else begin
            dcnt <= dcnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/boton.sv
// Long-press detector: one registered pulse on release of a
// debounced press that lasted at least MIN_TIME cycles.
module boton
   import boton_pkg::*;
#(
   parameter int MIN_TIME        = MIN_TIME_DEF,
   parameter int TIME_ANTIREBOTE = TIME_ANTIREBOTE_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic btn_out
);

   localparam int HW = $clog2(MIN_TIME + 1);
   localparam logic [HW-1:0] HMAX  = HW'(MIN_TIME);
   localparam logic [HW-1:0] HLAST = HW'(MIN_TIME - 1);
   localparam logic [HW-1:0] HONE  = HW'(1);

   logic          deb;
   logic [HW-1:0] hcnt;
   state_t        state;

   boton_antirebote #(
      .TIME_ANTIREBOTE(TIME_ANTIREBOTE)
   ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .btn_in (btn_in),
      .btn_deb(deb)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         hcnt    <= '0;
         btn_out <= 1'b0;
      end else begin
         btn_out <= 1'b0;
         unique case (state)
            IDLE: begin
               hcnt <= '0;
               // the rising cycle already counts toward the hold
               if (deb) begin
                  hcnt  <= HONE;
                  state <= (MIN_TIME == 1) ? LONG : PRESS;
               end
            end
            PRESS: begin
               if (!deb) begin
                  state <= IDLE;
                  hcnt  <= '0;
               end else begin
                  hcnt <= hcnt + 1'b1;
                  if (hcnt == HLAST) state <= LONG;
               end
            end
            LONG: begin
               if (deb && hcnt != HMAX) hcnt <= hcnt + 1'b1;
               if (!deb) begin
                  state   <= FIRE;
                  btn_out <= 1'b1;
               end
            end
            FIRE: begin
               state <= IDLE;
               hcnt  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_boton.sv
// Scoreboard bench for boton: stimulus queues expected pulse
// cycles, a monitor branch pops and compares on every pulse.
module tb_boton;
   import boton_pkg::*;

   localparam int MT  = 500;
   localparam int TA  = 10;
   localparam int LAT = 2 + TA + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_in = 1'b0;
   logic btn_out;

   int cyc = 0;
   int total = 0;
   int bad = 0;
   int pulses = 0;
   int base = 0;
   int exp_q[$];

   boton #(
      .MIN_TIME(MT),
      .TIME_ANTIREBOTE(TA)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .btn_in (btn_in),
      .btn_out(btn_out)
   );

   always #10 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, want);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic press(input int n, input bit qual);
      @(posedge clk);
      #1 btn_in = 1'b1;
      repeat (n) @(posedge clk);
      #1 btn_in = 1'b0;
      if (qual) exp_q.push_back(cyc + LAT);
   endtask

   task automatic phase_end(input string name, input int want);
      idle(40);
      check({name, " queue"}, exp_q.size(), 0);
      check({name, " pulses"}, pulses - base, want);
      base = pulses;
   endtask

   initial begin
      fork
         begin : stim
            rst = 1'b1;
            btn_in = 1'b1;
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               check("reset out", int'(btn_out), 0);
            end
            @(posedge clk);
            #1 rst = 1'b0;
            btn_in = 1'b0;
            @(negedge clk);
            check("reset state", int'(dut.state), int'(IDLE));
            check("reset out after", int'(btn_out), 0);
            idle(20);

            press(500, 1'b1);
            phase_end("long", 1);

            press(150, 1'b0);
            idle(50);
            press(150, 1'b0);
            phase_end("short", 0);

            press(MT - 1, 1'b0);
            phase_end("thr499", 0);
            press(MT, 1'b1);
            phase_end("thr500", 1);

            press(5, 1'b0);
            phase_end("glitch", 0);

            for (int i = 0; i < 3; i++) begin
               press(4, 1'b0);
               idle(4);
            end
            press(600, 1'b1);
            phase_end("bounce", 1);

            press(2000, 1'b1);
            phase_end("hold", 1);

            @(posedge clk);
            #1 btn_in = 1'b1;
            repeat (550) @(posedge clk);
            #1 rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
            repeat (100) @(posedge clk);
            #1 btn_in = 1'b0;
            phase_end("rst mid", 0);
         end
         begin : mon
            int e;
            forever begin
               @(negedge clk);
               if (btn_out === 1'b1) begin
                  pulses++;
                  total++;
                  if (exp_q.size() == 0) begin
                     bad++;
                     $display("FAIL pulse: unexpected at cycle %0d, want none", cyc);
                  end else begin
                     e = exp_q.pop_front();
                     if (e != cyc) begin
                        bad++;
                        $display("FAIL pulse: at cycle %0d, want %0d", cyc, e);
                     end
                  end
               end
            end
         end
         begin : wdog
            #2ms;
            $display("FAIL watchdog: time %0t, want end before 2ms", $time);
            $fatal(1, "watchdog");
         end
      join_any
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/boton.md
Name: boton

Overview:
- Push-button conditioner for the user-input front end.
- Synchronises the raw pad signal `btn_in` and removes contact bounce.
- Emits a single-cycle `btn_out` pulse on release, but only when the debounced press lasted at least MIN_TIME clock cycles.
- Short taps and glitches produce no output; one qualifying press gives exactly one event.

Parameters:
- MIN_TIME, 500: minimum debounced hold duration in clock cycles for a press to count; must be >= 1.
- TIME_ANTIREBOTE, 10: debounce window in clock cycles; the input must stay stable this long before the debounced level changes; must be >= 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- btn_in  input  1  raw asynchronous button, active-high (1 = pressed).
- btn_out  output  1  registered one-cycle pulse marking a valid long-press release.

Behaviour:
- Reset (rst=1 at a clock edge):
  - synchroniser flops, debounced level, debounce counter and hold counter clear to 0;
  - FSM goes to IDLE; btn_out=0.
  - Takes priority over every other event, including mid-press: the interrupted press is discarded and produces no pulse.
- Synchroniser: 2-flop chain on `btn_in`, giving `sync`. Latency 2 cycles.
- Debounce filter:
  - Holds debounced level `deb` and counter `dcnt` (width $clog2(TIME_ANTIREBOTE+1)).
  - If sync==deb: dcnt<=0.
  - Otherwise dcnt increments. When dcnt reaches TIME_ANTIREBOTE-1, deb<=sync and dcnt<=0.
  - Net effect: `deb` changes only after `sync` has differed from it for TIME_ANTIREBOTE consecutive cycles. Any shorter excursion resets the count and is ignored.
  - Both edges are delayed equally, 2+TIME_ANTIREBOTE cycles, so a clean press of N cycles yields `deb` high for N cycles.
- Hold counter `hcnt`:
  - Width $clog2(MIN_TIME+1).
  - Increments each cycle deb==1 and saturates at MIN_TIME; no wrap-around.
  - Cleared in IDLE.
- FSM states:
  - IDLE: waiting; hcnt=0. deb rises -> PRESS.
  - PRESS: counting.
    - deb falls while hcnt<MIN_TIME -> IDLE, no pulse.
    - hcnt reaches MIN_TIME -> LONG.
  - LONG: qualified hold; stays here for any further hold length. deb falls -> FIRE.
  - FIRE: btn_out=1 for exactly this one cycle; next state IDLE unconditionally.
- btn_out is registered, decoded from state FIRE.
- Boundaries:
  - Debounced press of exactly MIN_TIME cycles qualifies; MIN_TIME-1 cycles does not.
  - Indefinite hold never pulses until release.
  - A new press arriving during FIRE is seen from IDLE next cycle.
  - Release-to-pulse latency: 2+TIME_ANTIREBOTE+1 cycles after the raw falling edge.

Decomposition:
- Shared package: FSM state enum (IDLE, PRESS, LONG, FIRE, 2-bit), and the default MIN_TIME / TIME_ANTIREBOTE constants.
- Sub-module `boton_antirebote`:
  - Ports: clk, rst, btn_in, btn_deb.
  - Contains the 2-flop synchroniser and debounce filter, parameterised by TIME_ANTIREBOTE.
  - Top level instantiates it, then adds the hold counter, FSM and output register.

Test Plan:
- Reset: hold rst=1 for 5 cycles with btn_in=1 -> btn_out=0 throughout; FSM IDLE after release of rst.
- Long press: 20 ns clock, MIN_TIME=500, TIME_ANTIREBOTE=10; btn_in=1 for 10 us (500 cycles), then 0 -> exactly one btn_out pulse, 1 cycle wide, 13 cycles after the falling edge.
- Short press: btn_in=1 for 3 us (150 cycles), twice with 1 us gaps -> btn_out stays 0.
- Threshold: clean presses of 499 and 500 cycles -> no pulse for 499; one pulse for 500.
- Bounce and glitch:
  - 5-cycle glitch -> no deb change, no pulse.
  - Press preceded by 3 bounces of 4 cycles each, then 600 cycles held -> single pulse on release.
- Hold and reset mid-press:
  - btn_in held 2000 cycles -> no pulse before release, one pulse after.
  - Separately, rst asserted at cycle 550 of a press -> no pulse on the later release.
